alu_arbiter: RTL and testbench

Shares the single 18-bit combinational ALU between two independent requesters (e.g. the execute stage and the address/branch unit) using valid/ready handshakes and round-robin arbitration. The block registers operands, drives the external ALU for exactly one cycle per operation, and returns a registered result and zero flag to the requester that issued it. It sits between the requesters and the ALU and is the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_arbiter_rr_arb2.sv | 30 +++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: data/op widths, ALU op codes and FSM encoding.
package alu_pkg;

    localparam int W   = 18;
    localparam int OPW = 3;

    localparam logic [OPW-1:0] ALU_ADD  = 3'b000;
    localparam logic [OPW-1:0] ALU_SUB  = 3'b001;
    localparam logic [OPW-1:0] ALU_NAND = 3'b010;
    localparam logic [OPW-1:0] ALU_NOR  = 3'b011;
    localparam logic [OPW-1:0] ALU_SRL  = 3'b100;
    localparam logic [OPW-1:0] ALU_SRA  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Codes 110/111 have no ALU function assigned.
    function automatic logic is_illegal_op(input logic [OPW-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer moves to the loser whenever a grant is accepted.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant
);

    logic rr_ptr;

    always_comb begin
        grant = rr_ptr;
        if (valid0 && !valid1) begin
            grant = 1'b0;
        end else if (valid1 && !valid0) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters (round-robin).
// Optional feature macro: ALU_ARB_ILLEGAL_OP_EN flags ops 110/111 via rsp_err.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_zero,
    output logic           rsp_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_ctrl,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_zero,
    output logic           busy
);

    state_t         state, state_nx;
    logic           grant;
    logic           accept;
    logic           gid;
    logic [W-1:0]   op_a, op_b;
    logic [OPW-1:0] op_c;
    logic [W-1:0]   data_r;
    logic           zero_r;
    logic           rsp_take;

    assign accept   = (state == ST_IDLE) && (req0_valid || req1_valid);
    assign rsp_take = gid ? rsp1_ready : rsp0_ready;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Ready is gated by rst_n so it reads 0 while reset is held.
    assign req0_ready = rst_n && (state == ST_IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == ST_IDLE) && req1_valid &&  grant;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept)   state_nx = ST_EXEC;
            ST_EXEC:               state_nx = ST_RESP;
            ST_RESP: if (rsp_take) state_nx = ST_IDLE;
            default:               state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Accept: operand registers feed the ALU directly and only change here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            op_c <= '0;
            gid  <= 1'b0;
        end else if (accept) begin
            op_a <= grant ? req1_a  : req0_a;
            op_b <= grant ? req1_b  : req0_b;
            op_c <= grant ? req1_op : req0_op;
            gid  <= grant;
        end
    end

    // EXEC: capture the ALU result.
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            zero_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (state == ST_EXEC) begin
            if (is_illegal_op(op_c)) begin
                data_r <= '0;
                zero_r <= 1'b0;
                err_r  <= 1'b1;
            end else begin
                data_r <= alu_out;
                zero_r <= alu_zero;
                err_r  <= 1'b0;
            end
        end
    end

    assign rsp_err = err_r;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            zero_r <= 1'b0;
        end else if (state == ST_EXEC) begin
            data_r <= alu_out;
            zero_r <= alu_zero;
        end
    end

    assign rsp_err = 1'b0;
`endif

    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_ctrl   = op_c;
    assign rsp_data   = data_r;
    assign rsp_zero   = zero_r;
    assign rsp0_valid = (state == ST_RESP) && !gid;
    assign rsp1_valid = (state == ST_RESP) &&  gid;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the external ALU, checks every cycle against a
// transaction-level reference, and pins key results with literal expectations.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0] req0_op, req1_op;
    logic           rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_zero, rsp_err;
    logic [W-1:0]   alu_a, alu_b, alu_out;
    logic [OPW-1:0] alu_ctrl;
    logic           alu_zero;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [OPW-1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        sa = a;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a >> b;
            3'd5:    return W'(sa >>> b);
            default: return '0;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_ctrl, alu_a, alu_b);
    assign alu_zero = (alu_out == '0);

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction with an age in cycles since accept.
    bit             m_pending, m_owner, m_rr;
    int             m_age;
    logic [W-1:0]   m_a, m_b, m_data;
    logic [OPW-1:0] m_op;
    bit             m_zero, m_err;

    initial begin
        bit           w, v0, v1;
        logic [W-1:0] r;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                m_pending = 0; m_owner = 0; m_rr = 0; m_age = 0;
                m_a = '0; m_b = '0; m_op = '0; m_data = '0; m_zero = 0; m_err = 0;
            end
            v0 = req0_valid;
            v1 = req1_valid;
            w  = (v0 && v1) ? m_rr : v1;
            chk("req0_ready", req0_ready, rst_n && !m_pending && v0 && !w);
            chk("req1_ready", req1_ready, rst_n && !m_pending && v1 &&  w);
            chk("rsp0_valid", rsp0_valid, m_pending && m_age >= 1 && !m_owner);
            chk("rsp1_valid", rsp1_valid, m_pending && m_age >= 1 &&  m_owner);
            chk("busy", busy, m_pending);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_ctrl", alu_ctrl, m_op);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_zero", rsp_zero, m_zero);
            chk("rsp_err", rsp_err, m_err);
            if (rst_n) begin
                if (!m_pending) begin
                    if (v0 || v1) begin
                        m_pending = 1; m_owner = w; m_age = 0; m_rr = !w;
                        m_a  = w ? req1_a  : req0_a;
                        m_b  = w ? req1_b  : req0_b;
                        m_op = w ? req1_op : req0_op;
                    end
                end else if (m_age == 0) begin
                    m_age = 1;
                    r = alu_fn(m_op, m_a, m_b);
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    if (m_op >= 3'd6) begin
                        m_data = '0; m_zero = 0; m_err = 1;
                    end else begin
                        m_data = r; m_zero = (r == '0); m_err = 0;
                    end
`else
                    m_data = r; m_zero = (r == '0); m_err = 0;
`endif
                end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                    m_pending = 0;
                end
            end
        end
    end

    task automatic wait_rsp(input bit k, input string name);
        bit got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            #3;
            got = k ? rsp1_valid : rsp0_valid;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no response within 12 cycles, expected rsp%0d_valid", name, k);
        end
    endtask

    task automatic set_req(input bit k, input bit v, input logic [OPW-1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (k) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 18'h3FFFF;
            2:       return 18'h20000;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        bit seen;
        rst_n = 1'b0;
        set_req(0, 0, 3'd0, '0, '0);
        set_req(1, 0, 3'd0, '0, '0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("reset busy", busy, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset req0_ready", req0_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 5+3 from requester 0 alone
        @(negedge clk);
        set_req(0, 1, ALU_ADD, 18'd5, 18'd3);
        #3;
        chk("add req0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #3;
        chk("add rsp0_valid", rsp0_valid, 1);
        chk("add rsp_data", rsp_data, 8);
        chk("add rsp_zero", rsp_zero, 0);

        // Tie from reset: req0 first, then req1, then req0 again
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1, ALU_SUB, 18'd7, 18'd7);
        set_req(1, 1, ALU_NOR, 18'd0, 18'd0);
        wait_rsp(0, "tie first");
        chk("tie sub data", rsp_data, 0);
        chk("tie sub zero", rsp_zero, 1);
        wait_rsp(1, "tie second");
        chk("tie nor data", rsp_data, 18'h3FFFF);
        chk("tie nor zero", rsp_zero, 0);
        wait_rsp(0, "tie third");
        chk("tie third data", rsp_data, 0);
        @(negedge clk);
        set_req(0, 0, 3'd0, '0, '0);
        set_req(1, 0, 3'd0, '0, '0);

        // Backpressure on rsp1 with SRA; req0 SRL waits
        @(negedge clk);
        rsp1_ready = 1'b0;
        set_req(0, 1, ALU_SRL, 18'h20000, 18'd4);
        set_req(1, 1, ALU_SRA, 18'h20000, 18'd4);
        wait_rsp(1, "sra rsp");
        chk("sra data", rsp_data, 18'h3E000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) req1_valid = 1'b0;
            #3;
            chk("bp rsp1_valid", rsp1_valid, 1);
            chk("bp rsp_data", rsp_data, 18'h3E000);
            chk("bp req0_ready", req0_ready, 0);
        end
        @(negedge clk);
        rsp1_ready = 1'b1;
        #3;
        chk("release req0_ready", req0_ready, 0);
        @(negedge clk);
        #3;
        chk("after release req0_ready", req0_ready, 1);
        wait_rsp(0, "srl rsp");
        chk("srl data", rsp_data, 18'h02000);
        @(negedge clk);
        req0_valid = 1'b0;

        // Op 111
        @(negedge clk);
        set_req(0, 1, 3'b111, 18'd1, 18'd2);
        wait_rsp(0, "op7 rsp");
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("op7 err", rsp_err, 1);
        chk("op7 zero", rsp_zero, 0);
`else
        chk("op7 err", rsp_err, 0);
        chk("op7 zero", rsp_zero, 1);
`endif
        chk("op7 data", rsp_data, 0);
        @(negedge clk);
        req0_valid = 1'b0;

        // Reset during EXEC
        @(negedge clk);
        set_req(0, 1, ALU_ADD, 18'd1, 18'd1);
        #3;
        chk("exec-rst req0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("exec-rst busy", busy, 0);
        chk("exec-rst alu_a", alu_a, 0);
        chk("exec-rst rsp0_valid", rsp0_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #3;
            if (rsp0_valid || rsp1_valid) seen = 1;
        end
        chk("exec-rst no response", seen, 0);

        // Randomized traffic, occasional reset pulses
        repeat (3000) begin
            @(negedge clk);
            rst_n      = ($urandom_range(0, 199) != 0);
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_op    = OPW'($urandom_range(0, 7));
            req1_op    = OPW'($urandom_range(0, 7));
            req0_a     = rnd_opnd();
            req0_b     = rnd_opnd();
            req1_a     = rnd_opnd();
            req1_b     = rnd_opnd();
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
